// File: rtl/c880_bist_ctrl.sv
// BIST sequencer for c880: LFSR pattern source, MISR response compactor.
// Optional golden compare enabled by C880_BIST_GOLDEN_CMP_EN.
module c880_bist_ctrl #(
  parameter int unsigned NUM_PATTERNS = 1024,
  parameter logic [59:0] SEED         = 60'h0000000_00000001,
  parameter logic [25:0] GOLDEN       = 26'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [25:0] response_i,
  output logic [59:0] pattern_o,
  output logic        busy,
  output logic        done,
  output logic [25:0] signature,
  output logic        pass
);

  localparam int CW = $clog2(NUM_PATTERNS + 1);
  localparam logic [CW-1:0] LAST = CW'(NUM_PATTERNS - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // MISR feedback taps for x^26+x^6+x^2+x+1 (bits 0,1,2,6)
  localparam logic [25:0] TAPS = 26'h0000047;

  logic [1:0]    r_state;
  logic [59:0]   r_lfsr;
  logic [25:0]   r_misr;
  logic [CW-1:0] r_cnt;
  logic [59:0]   r_pattern;
  logic          r_busy;
  logic          r_done;

  logic [59:0]   w_lfsr_nxt;
  logic [25:0]   w_misr_nxt;
  logic          w_last;

  // Next-state functions of the pattern and signature registers
  always_comb begin
    w_lfsr_nxt = {r_lfsr[58:0], r_lfsr[59] ^ r_lfsr[58]};
    w_misr_nxt = {r_misr[24:0], 1'b0} ^ response_i;
    if (r_misr[25]) begin
      w_misr_nxt = w_misr_nxt ^ TAPS;
    end
    w_last = (r_cnt == LAST);
  end

  // Sequencer FSM with LFSR, MISR and pattern register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_lfsr    <= SEED;
      r_misr    <= '0;
      r_cnt     <= '0;
      r_pattern <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state   <= S_RUN;
            r_lfsr    <= SEED;
            r_misr    <= '0;
            r_cnt     <= '0;
            r_pattern <= SEED;
            r_busy    <= 1'b1;
          end
        end
        S_RUN: begin
          r_misr <= w_misr_nxt;
          r_lfsr <= w_lfsr_nxt;
          r_cnt  <= r_cnt + ONE;
          if (w_last) begin
            r_state   <= S_DONE;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_pattern <= '0;
          end else begin
            r_pattern <= w_lfsr_nxt;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state   <= S_IDLE;
          r_busy    <= 1'b0;
          r_done    <= 1'b0;
          r_pattern <= '0;
        end
      endcase
    end
  end

`ifdef C880_BIST_GOLDEN_CMP_EN
  logic r_pass;

  // Golden compare on the final signature, cleared by a new run
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pass <= 1'b0;
    end else if (r_state == S_IDLE && start) begin
      r_pass <= 1'b0;
    end else if (r_state == S_RUN && w_last) begin
      r_pass <= (w_misr_nxt == GOLDEN);
    end
  end

  assign pass = r_pass;
`else
  logic [25:0] w_unused_golden;
  assign w_unused_golden = GOLDEN;
  assign pass = 1'b0;
`endif

  assign pattern_o = r_pattern;
  assign busy      = r_busy;
  assign done      = r_done;
  assign signature = r_misr;

endmodule
